// File: rtl/program_loader.sv
// program_loader: assembles a little-endian byte stream into 32-bit words,
// writes them to instruction ROM and releases the CPU once the image is loaded.
module program_loader #(
    parameter int ROM_ADDRESS_BITWIDTH = 12
) (
    input  logic                            clk,
    input  logic                            reset,
    input  logic [7:0]                      in_data,
    input  logic                            in_valid,
    output logic                            in_ready,
    input  logic                            restart,
    output logic                            rom_wren,
    output logic [ROM_ADDRESS_BITWIDTH-1:0] rom_address,
    output logic [31:0]                     rom_write_data,
    output logic                            cpu_reset_n,
    output logic                            done,
    output logic                            error,
    output logic [31:0]                     word_count
);
    typedef enum logic [1:0] {S_HEADER, S_LOAD, S_DONE, S_ERROR} state_t;
    localparam logic [31:0] CAPACITY = 32'd1 << (ROM_ADDRESS_BITWIDTH - 2);
    state_t                          r_state, w_next;
    logic [1:0]                      r_byte_idx;
    logic [23:0]                     r_asm;
    logic [31:0]                     r_len, r_word_count, r_wdata;
    logic [ROM_ADDRESS_BITWIDTH-1:0] r_addr;
    logic                            r_wren, r_done, r_error, r_cpu_rst_n;
    logic                            w_accept, w_last, w_finish;
    logic [31:0]                     w_word;
    assign w_accept = in_valid && in_ready;
    assign w_last   = w_accept && (r_byte_idx == 2'd3);
    assign w_word   = {in_data, r_asm};
    assign w_finish = (r_state == S_DONE || r_state == S_ERROR) && restart;
    always_ff @(posedge clk) begin
        if (reset) r_state <= S_HEADER;
        else       r_state <= w_next;
    end
    always_comb begin
        w_next = r_state;
        case (r_state)
            S_HEADER: if (w_last) w_next = (w_word == 32'd0) ? S_DONE :
                                           (w_word > CAPACITY) ? S_ERROR : S_LOAD;
            S_LOAD:   if (r_word_count == r_len) w_next = S_DONE;
            default:  if (restart) w_next = S_HEADER;
        endcase
    end
    always_comb begin
        in_ready = (r_state == S_HEADER) || (r_state == S_LOAD);
    end
    // Bytes enter at the top so byte 0 ends up in the low lane of the word.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_byte_idx   <= '0;
            r_asm        <= '0;
            r_len        <= '0;
            r_word_count <= '0;
            r_wdata      <= '0;
            r_addr       <= '0;
            r_wren       <= 1'b0;
            r_done       <= 1'b0;
            r_error      <= 1'b0;
            r_cpu_rst_n  <= 1'b0;
        end else begin
            r_wren <= w_last && (r_state == S_LOAD);
            if (w_accept) begin
                r_byte_idx <= r_byte_idx + 2'd1;
                r_asm      <= {in_data, r_asm[23:8]};
            end
            if (w_last && r_state == S_HEADER) begin
                r_len        <= w_word;
                r_word_count <= '0;
            end
            if (w_last && r_state == S_LOAD) begin
                r_wdata      <= w_word;
                r_addr       <= {r_word_count[ROM_ADDRESS_BITWIDTH-3:0], 2'b00};
                r_word_count <= r_word_count + 32'd1;
            end
            if (w_finish) begin
                r_word_count <= '0;
                r_byte_idx   <= '0;
            end
            r_done      <= (w_next == S_DONE);
            r_error     <= (w_next == S_ERROR);
            r_cpu_rst_n <= (w_next == S_DONE);
        end
    end
    assign rom_wren       = r_wren;
    assign rom_address    = r_addr;
    assign rom_write_data = r_wdata;
    assign cpu_reset_n    = r_cpu_rst_n;
    assign done           = r_done;
    assign error          = r_error;
    assign word_count     = r_word_count;
endmodule

// File: tb/tb_program_loader.sv
// tb_program_loader: randomized image loads checked against a list of
// expected ROM writes derived directly from the image contents.
module tb_program_loader;
    logic        clk = 1'b0;
    logic        reset, in_valid, restart;
    logic [7:0]  in_data;
    logic        in_ready, rom_wren, cpu_reset_n, done, error;
    logic [11:0] rom_address;
    logic [31:0] rom_write_data, word_count;
    int          n_checks = 0;
    int          n_errors = 0;
    logic [31:0] img[$];
    logic [43:0] wr_q[$];

    program_loader #(.ROM_ADDRESS_BITWIDTH(12)) dut (
        .clk(clk), .reset(reset), .in_data(in_data), .in_valid(in_valid),
        .in_ready(in_ready), .restart(restart), .rom_wren(rom_wren),
        .rom_address(rom_address), .rom_write_data(rom_write_data),
        .cpu_reset_n(cpu_reset_n), .done(done), .error(error),
        .word_count(word_count)
    );

    always #5 clk = ~clk;

    always @(negedge clk) if (rom_wren) wr_q.push_back({rom_address, rom_write_data});

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic apply_reset();
        reset = 1'b1;
        tick();
        tick();
        reset = 1'b0;
        wr_q.delete();
    endtask

    task automatic send_byte(input logic [7:0] b, input int gap_pct);
        for (int g = 0; g < 6 && $urandom_range(99) < gap_pct; g++) begin
            in_valid = 1'b0;
            in_data  = 8'($urandom);
            tick();
        end
        in_valid = 1'b1;
        in_data  = b;
        tick();
        in_valid = 1'b0;
    endtask

    task automatic send_word(input logic [31:0] w, input int gap_pct);
        for (int i = 0; i < 4; i++) send_byte(w[8*i +: 8], gap_pct);
    endtask

    task automatic send_image(input int gap_pct);
        send_word(32'(img.size()), gap_pct);
        foreach (img[i]) send_word(img[i], gap_pct);
    endtask

    task automatic random_image(input int n);
        img.delete();
        for (int i = 0; i < n; i++) img.push_back($urandom);
    endtask

    task automatic test_reset();
        reset = 1'b1; in_valid = 1'b0; in_data = 8'h00; restart = 1'b0;
        tick();
        tick();
        reset = 1'b0;
        @(negedge clk);
        n_checks++;
        if ({rom_wren, rom_address, rom_write_data, cpu_reset_n, done, error, word_count} !== '0) begin
            n_errors++;
            $display("FAIL reset_outputs wren=%b addr=%h data=%h rst_n=%b done=%b err=%b wc=%0d expected all zero",
                     rom_wren, rom_address, rom_write_data, cpu_reset_n, done, error, word_count);
        end
        n_checks++;
        if (in_ready !== 1'b1) begin
            n_errors++;
            $display("FAIL reset_ready got %b expected 1", in_ready);
        end
        tick();
    endtask

    task automatic test_normal();
        apply_reset();
        img = '{32'h0000_0013, 32'h0010_0093};
        send_image(0);
        @(negedge clk);
        n_checks++;
        if (rom_wren !== 1'b1 || done !== 1'b0) begin
            n_errors++;
            $display("FAIL normal_last_pulse wren=%b done=%b expected wren=1 done=0", rom_wren, done);
        end
        tick();
        @(negedge clk);
        n_checks++;
        if ({done, cpu_reset_n, in_ready, rom_wren} !== 4'b1100 || word_count !== 32'd2) begin
            n_errors++;
            $display("FAIL normal_done done=%b rst_n=%b ready=%b wren=%b wc=%0d expected 1,1,0,0 wc=2",
                     done, cpu_reset_n, in_ready, rom_wren, word_count);
        end
        n_checks++;
        if (wr_q.size() != 2 || wr_q[0] !== {12'h000, 32'h0000_0013} || wr_q[1] !== {12'h004, 32'h0010_0093}) begin
            n_errors++;
            $display("FAIL normal_writes got %0d writes first=%h expected 2 writes 000/00000013 004/00100093",
                     wr_q.size(), wr_q.size() > 0 ? wr_q[0] : 44'h0);
        end
    endtask

    task automatic test_zero_length();
        apply_reset();
        img.delete();
        send_image(0);
        @(negedge clk);
        n_checks++;
        if ({done, cpu_reset_n, in_ready, error} !== 4'b1100) begin
            n_errors++;
            $display("FAIL zero_done done=%b rst_n=%b ready=%b err=%b expected 1,1,0,0",
                     done, cpu_reset_n, in_ready, error);
        end
        send_word($urandom, 0);
        @(negedge clk);
        n_checks++;
        if (wr_q.size() != 0 || word_count !== 32'd0 || done !== 1'b1) begin
            n_errors++;
            $display("FAIL zero_no_writes writes=%0d wc=%0d done=%b expected 0,0,1", wr_q.size(), word_count, done);
        end
    endtask

    task automatic test_overflow();
        apply_reset();
        send_word(32'd1025, 0);
        @(negedge clk);
        n_checks++;
        if ({error, done, cpu_reset_n, in_ready} !== 4'b1000) begin
            n_errors++;
            $display("FAIL overflow_state err=%b done=%b rst_n=%b ready=%b expected 1,0,0,0",
                     error, done, cpu_reset_n, in_ready);
        end
        send_word($urandom, 0);
        @(negedge clk);
        n_checks++;
        if (wr_q.size() != 0 || error !== 1'b1) begin
            n_errors++;
            $display("FAIL overflow_no_writes writes=%0d err=%b expected 0 writes err=1", wr_q.size(), error);
        end
        apply_reset();
        random_image(1024);
        send_image(0);
        tick();
        @(negedge clk);
        n_checks++;
        if (wr_q.size() != 1024 || done !== 1'b1 || error !== 1'b0 || word_count !== 32'd1024) begin
            n_errors++;
            $display("FAIL capacity_load writes=%0d done=%b err=%b wc=%0d expected 1024,1,0,1024",
                     wr_q.size(), done, error, word_count);
        end else begin
            int bad = 0;
            foreach (img[i]) if (wr_q[i] !== {12'(4 * i), img[i]}) bad++;
            n_checks++;
            if (bad != 0 || wr_q[1023][43:32] !== 12'hFFC) begin
                n_errors++;
                $display("FAIL capacity_writes bad=%0d last_addr=%h expected 0 bad last_addr=ffc", bad, wr_q[1023][43:32]);
            end
        end
    endtask

    task automatic test_gapped();
        logic [43:0] ref_q[$];
        apply_reset();
        random_image(3);
        send_image(0);
        tick();
        ref_q = wr_q;
        apply_reset();
        send_image(50);
        for (int i = 0; i < 4; i++) tick();
        n_checks++;
        if (wr_q.size() != 3 || done !== 1'b1) begin
            n_errors++;
            $display("FAIL gapped_count writes=%0d done=%b expected 3 writes done=1", wr_q.size(), done);
        end
        for (int i = 0; i < 3 && i < wr_q.size(); i++) begin
            n_checks++;
            if (wr_q[i] !== {12'(4 * i), img[i]} || ref_q.size() <= i || wr_q[i] !== ref_q[i]) begin
                n_errors++;
                $display("FAIL gapped_word%0d got %h expected %h", i, wr_q[i], {12'(4 * i), img[i]});
            end
        end
    endtask

    task automatic test_reset_mid_word();
        logic [31:0] w;
        apply_reset();
        w = $urandom;
        send_word(32'd2, 0);
        send_word(w, 0);
        send_byte(8'($urandom), 0);
        send_byte(8'($urandom), 0);
        reset = 1'b1;
        tick();
        reset = 1'b0;
        @(negedge clk);
        n_checks++;
        if ({rom_wren, rom_address, rom_write_data, cpu_reset_n, done, error, word_count} !== '0 || in_ready !== 1'b1) begin
            n_errors++;
            $display("FAIL midreset_outputs wren=%b addr=%h data=%h wc=%0d ready=%b expected zeros ready=1",
                     rom_wren, rom_address, rom_write_data, word_count, in_ready);
        end
        n_checks++;
        if (wr_q.size() != 1 || wr_q[0] !== {12'h000, w}) begin
            n_errors++;
            $display("FAIL midreset_first writes=%0d expected exactly 1 write of %h", wr_q.size(), w);
        end
        wr_q.delete();
        random_image(1);
        send_image(0);
        tick();
        @(negedge clk);
        n_checks++;
        if (wr_q.size() != 1 || wr_q[0] !== {12'h000, img[0]} || done !== 1'b1) begin
            n_errors++;
            $display("FAIL midreset_reload writes=%0d done=%b expected 1 write 000/%h done=1", wr_q.size(), done, img[0]);
        end
    endtask

    task automatic test_restart();
        restart  = 1'b1;
        in_valid = 1'b1;
        in_data  = 8'hAA;
        tick();
        restart  = 1'b0;
        in_valid = 1'b0;
        wr_q.delete();
        @(negedge clk);
        n_checks++;
        if ({done, cpu_reset_n, error, in_ready} !== 4'b0001 || word_count !== 32'd0) begin
            n_errors++;
            $display("FAIL restart_clear done=%b rst_n=%b err=%b ready=%b wc=%0d expected 0,0,0,1 wc=0",
                     done, cpu_reset_n, error, in_ready, word_count);
        end
        img = '{32'h0000_0000};
        img[0] = $urandom;
        send_word(32'd1, 0);
        send_word({8'h00, img[0][23:0]}, 0);
        n_checks++;
        if (done !== 1'b0 || cpu_reset_n !== 1'b0) begin
            n_errors++;
            $display("FAIL restart_hold done=%b rst_n=%b expected 0,0", done, cpu_reset_n);
        end
        img[0] = {8'h00, img[0][23:0]};
        tick();
        @(negedge clk);
        n_checks++;
        if (wr_q.size() != 1 || wr_q[0] !== {12'h000, img[0]} || done !== 1'b1 || cpu_reset_n !== 1'b1) begin
            n_errors++;
            $display("FAIL restart_reload writes=%0d done=%b rst_n=%b expected 1 write 000/%h done=1 rst_n=1",
                     wr_q.size(), done, cpu_reset_n, img[0]);
        end
        restart = 1'b1;
        tick();
        restart = 1'b0;
        send_word(32'd2000, 0);
        restart = 1'b1;
        tick();
        restart = 1'b0;
        @(negedge clk);
        n_checks++;
        if ({error, in_ready, word_count} !== {2'b01, 32'd0}) begin
            n_errors++;
            $display("FAIL restart_from_error err=%b ready=%b wc=%0d expected 0,1,0", error, in_ready, word_count);
        end
    endtask

    initial begin
        test_reset();
        test_normal();
        test_zero_length();
        test_overflow();
        test_gapped();
        test_reset_mid_word();
        test_restart();
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end
endmodule
